// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx word serializer among NUM_REQ producers.
// One word is granted at a time; the next grant waits for tx_done or a watchdog abort.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned TIMEOUT_CLKS = 16384
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       tx_start,
    output logic [WIDTH-1:0]           tx_din,
    input  logic                       tx_active,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err
);

    localparam int unsigned     IdxW    = $clog2(NUM_REQ);
    localparam int unsigned     CntW    = $clog2(TIMEOUT_CLKS);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CLKS - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   ptr_q;
    logic [CntW-1:0]   cnt_q;

    logic              win_valid;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   cand;
    logic [IdxW-1:0]   ptr_next;
    logic [WIDTH-1:0]  win_data;
    logic [NUM_REQ-1:0] win_onehot;

    // First asserted request found scanning upward from ptr_q, wrapping at NUM_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IdxW'((32'(ptr_q) + off) % NUM_REQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IdxW'(i)) begin
                win_data      = data[i*WIDTH +: WIDTH];
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign ptr_next = (win_idx == IdxLast) ? '0 : win_idx + IdxW'(1);

    // cnt_q counts cycles since the launch cycle, so the abort lands TIMEOUT_CLKS after tx_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cnt_q    <= '0;
            tx_start <= 1'b0;
            tx_din   <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            err      <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (win_valid && !tx_active) begin
                        state_q  <= StLaunch;
                        tx_din   <= win_data;
                        grant_id <= win_idx;
                        ptr_q    <= ptr_next;
                        tx_start <= 1'b1;
                        ack      <= win_onehot;
                        busy     <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                StLaunch: begin
                    state_q <= StWait;
                    cnt_q   <= cnt_q + CntW'(1);
                end
                StWait: begin
                    if (tx_done) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transmitter stand-in, queue-driven producers and a
// cycle-level model of the grant/watchdog rules compared against the DUT every cycle.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned WIDTH        = 16;
    localparam int unsigned TIMEOUT_CLKS = 100;
    localparam int          FRAME_CLKS   = 72;

    typedef int iq_t[$];

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*WIDTH-1:0] data = '0;
    logic [NUM_REQ-1:0]       ack;
    logic                     tx_start;
    logic [WIDTH-1:0]         tx_din;
    logic                     tx_active = 1'b0;
    logic                     tx_done = 1'b0;
    logic                     busy;
    logic [1:0]               grant_id;
    logic                     err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .WIDTH       (WIDTH),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_din   (tx_din),
        .tx_active(tx_active),
        .tx_done  (tx_done),
        .busy     (busy),
        .grant_id (grant_id),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stand-in: done pulses done_delay cycles after the start cycle.
    int  done_delay = FRAME_CLKS;
    bit  suppress_done = 1'b0;
    bit  inject_done = 1'b0;
    int  stub_cnt = 0;
    logic [WIDTH-1:0] stub_word = '0;
    iq_t rx_words;

    always @(posedge clk) begin
        if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                tx_active <= 1'b0;
                tx_done   <= !suppress_done;
                if (!suppress_done) rx_words.push_back(int'(stub_word));
            end else begin
                tx_done <= inject_done;
            end
        end else begin
            tx_done <= inject_done;
            if (tx_start) begin
                tx_active <= 1'b1;
                stub_cnt  <= done_delay - 1;
                stub_word <= tx_din;
            end
        end
    end

    // Producers: each requester presents the head of its queue until acked.
    logic [WIDTH-1:0] pq [NUM_REQ][$];

    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            req[i] = (pq[i].size() > 0);
            data[i*WIDTH +: WIDTH] = (pq[i].size() > 0) ? pq[i][0] : '0;
        end
    end

    // Model: m_age is the number of cycles since the launch cycle of the open grant.
    bit               m_busy = 1'b0;
    int               m_age = 0;
    int               m_ptr = 0;
    int               m_w;
    int               m_c;
    iq_t              m_grants;
    logic             e_start = 1'b0;
    logic [NUM_REQ-1:0] e_ack = '0;
    logic             e_busy = 1'b0;
    logic [1:0]       e_gid = '0;
    logic [WIDTH-1:0] e_din = '0;
    logic             e_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_ptr  = 0;
            e_start = 1'b0;
            e_ack   = '0;
            e_gid   = '0;
            e_din   = '0;
            e_err   = 1'b0;
        end else begin
            e_start = 1'b0;
            e_ack   = '0;
            e_err   = 1'b0;
            if (!m_busy) begin
                if (req != '0 && !tx_active) begin
                    m_w = -1;
                    for (int k = 0; k < int'(NUM_REQ); k++) begin
                        m_c = (m_ptr + k) % int'(NUM_REQ);
                        if (m_w < 0 && req[m_c]) m_w = m_c;
                    end
                    e_start    = 1'b1;
                    e_ack[m_w] = 1'b1;
                    e_gid      = 2'(m_w);
                    e_din      = data[m_w*WIDTH +: WIDTH];
                    m_ptr      = (m_w + 1) % int'(NUM_REQ);
                    m_busy     = 1'b1;
                    m_age      = 0;
                    m_grants.push_back(m_w);
                end
            end else if (m_age >= 1 && tx_done) begin
                m_busy = 1'b0;
            end else if (m_age == int'(TIMEOUT_CLKS) - 1) begin
                m_busy = 1'b0;
                e_err  = 1'b1;
            end else begin
                m_age++;
            end
        end
        e_busy = m_busy;
    end

    // Per-cycle comparison plus an event log of what the DUT actually did.
    iq_t d_start_t;
    iq_t d_gid;
    iq_t d_err_t;
    int  d_err_total = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (tx_start !== e_start || ack !== e_ack || busy !== e_busy ||
                grant_id !== e_gid || tx_din !== e_din || err !== e_err) begin
                errors++;
                $display("FAIL outputs cyc=%0d got start=%b ack=%b busy=%b gid=%0d din=%h err=%b want start=%b ack=%b busy=%b gid=%0d din=%h err=%b",
                         cyc, tx_start, ack, busy, grant_id, tx_din, err,
                         e_start, e_ack, e_busy, e_gid, e_din, e_err);
            end
            if (tx_start) begin
                d_start_t.push_back(cyc);
                d_gid.push_back(int'(grant_id));
            end
            if (err) begin
                d_err_t.push_back(cyc);
                d_err_total++;
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_seq(input string name, input iq_t got, input int want[8], input int n);
        check({name, "_len"}, got.size(), n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", name, i), (i < got.size()) ? got[i] : -1, want[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = !m_busy && !busy && !tx_active && stub_cnt == 0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pq[i].size() != 0) q = 1'b0;
        return q;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!quiet() && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_within_budget"}, int'(n < budget), 1);
        tick(2);
    endtask

    task automatic clear_logs();
        d_start_t.delete();
        d_gid.delete();
        d_err_t.delete();
        m_grants.delete();
        rx_words.delete();
    endtask

    initial begin
        int t0;
        int n;

        tick(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", int'(busy), 0);
        check("reset_tx_din", int'(tx_din), 0);
        check("reset_grant_id", int'(grant_id), 0);
        check("reset_tx_start", int'(tx_start), 0);
        check("reset_ack", int'(ack), 0);

        // Stray completion pulse in IDLE must be ignored.
        inject_done = 1'b1;
        tick(1);
        inject_done = 1'b0;
        tick(3);
        check("stale_done_no_start", d_start_t.size(), 0);
        check("stale_done_no_err", d_err_total, 0);

        // All four requesters, requester 0 holding a second word.
        clear_logs();
        pq[0].push_back(16'h1111);
        pq[0].push_back(16'h5555);
        pq[1].push_back(16'h2222);
        pq[2].push_back(16'h3333);
        pq[3].push_back(16'h4444);
        wait_idle("rr_all", 800);
        check_seq("rr_model_order", m_grants, '{0, 1, 2, 3, 0, 0, 0, 0}, 5);
        check_seq("rr_dut_order", d_gid, '{0, 1, 2, 3, 0, 0, 0, 0}, 5);
        check_seq("rr_rx", rx_words, '{'h1111, 'h2222, 'h3333, 'h4444, 'h5555, 0, 0, 0}, 5);
        check("rr_back_to_back_gap", (d_start_t.size() > 1) ? d_start_t[1] - d_start_t[0] : -1,
              FRAME_CLKS + 2);

        // Single request on requester 2.
        clear_logs();
        t0 = cyc;
        pq[2].push_back(16'h00AB);
        wait_idle("single", 200);
        check("single_latency", (d_start_t.size() > 0) ? d_start_t[0] - t0 : -1, 1);
        check_seq("single_dut_gid", d_gid, '{2, 0, 0, 0, 0, 0, 0, 0}, 1);
        check("single_grant_id_held", int'(grant_id), 2);
        check_seq("single_rx", rx_words, '{'h00AB, 0, 0, 0, 0, 0, 0, 0}, 1);

        // Fairness: requester 3 arrives mid-frame while requester 0 stays high.
        clear_logs();
        pq[0].push_back(16'hA0A0);
        pq[0].push_back(16'hA1A1);
        tick(10);
        pq[3].push_back(16'h3C3C);
        wait_idle("fair", 400);
        check_seq("fair_model_order", m_grants, '{0, 3, 0, 0, 0, 0, 0, 0}, 3);
        check_seq("fair_dut_order", d_gid, '{0, 3, 0, 0, 0, 0, 0, 0}, 3);
        check_seq("fair_rx", rx_words, '{'hA0A0, 'h3C3C, 'hA1A1, 0, 0, 0, 0, 0}, 3);

        // Watchdog: first frame never completes, the queued word is granted afterwards.
        clear_logs();
        suppress_done = 1'b1;
        pq[1].push_back(16'h0BAD);
        pq[2].push_back(16'hBEEF);
        n = 0;
        while (d_err_t.size() == 0 && n < 300) begin
            tick(1);
            n++;
        end
        check("wd_err_seen", int'(d_err_t.size() > 0), 1);
        suppress_done = 1'b0;
        wait_idle("wd", 300);
        check("wd_err_delay", (d_err_t.size() > 0 && d_start_t.size() > 0) ?
              d_err_t[0] - d_start_t[0] : -1, 100);
        check("wd_regrant_gap", (d_err_t.size() > 0 && d_start_t.size() > 1) ?
              d_start_t[1] - d_err_t[0] : -1, 1);
        check_seq("wd_dut_order", d_gid, '{1, 2, 0, 0, 0, 0, 0, 0}, 2);
        check_seq("wd_rx", rx_words, '{'hBEEF, 0, 0, 0, 0, 0, 0, 0}, 1);

        // tx_done lands in the same cycle the watchdog expires: completion wins.
        clear_logs();
        done_delay = int'(TIMEOUT_CLKS) - 1;
        pq[3].push_back(16'hC0DE);
        wait_idle("coincide", 300);
        done_delay = FRAME_CLKS;
        check("coincide_no_err", d_err_t.size(), 0);
        check_seq("coincide_model_order", m_grants, '{3, 0, 0, 0, 0, 0, 0, 0}, 1);
        check_seq("coincide_rx", rx_words, '{'hC0DE, 0, 0, 0, 0, 0, 0, 0}, 1);

        // Reset mid-frame: in-flight frame finishes, next grant waits for tx_active to fall.
        clear_logs();
        pq[3].push_back(16'h7777);
        n = 0;
        while (d_start_t.size() == 0 && n < 50) begin
            tick(1);
            n++;
        end
        check("rst_first_start_seen", d_start_t.size(), 1);
        t0 = (d_start_t.size() > 0) ? d_start_t[0] : cyc;
        tick(19);
        pq[1].push_back(16'h1A1A);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_tx_din", int'(tx_din), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_ack", int'(ack), 0);
        wait_idle("rst", 300);
        check("rst_start_count", d_start_t.size(), 2);
        check("rst_regrant_gap", (d_start_t.size() > 1) ? d_start_t[1] - t0 : -1, FRAME_CLKS + 1);
        check("rst_regrant_gid", (d_gid.size() > 1) ? d_gid[1] : -1, 1);
        check("rst_no_err", d_err_t.size(), 0);
        check_seq("rst_rx", rx_words, '{'h7777, 'h1A1A, 0, 0, 0, 0, 0, 0}, 2);

        check("total_err_pulses", d_err_total, 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
